// File: rtl/aud_mode_ctrl.sv
// Mode sequencer for the audio record/playback path: INIT/IDLE/RECORD/PLAY control,
// recorder/DSP command pulses, SRAM direction, recorded length and playback speed/mode.
module aud_mode_ctrl #(
    parameter int unsigned ADDR_W    = 20,
    parameter int unsigned SPEED_W   = 4,
    parameter int unsigned MAX_SPEED = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_init_finished,
    input  logic              i_key_rec,
    input  logic              i_key_play,
    input  logic              i_key_stop,
    input  logic              i_key_spd_up,
    input  logic              i_key_spd_dn,
    input  logic              i_key_mode,
    input  logic [ADDR_W-1:0] i_rec_addr,
    input  logic [ADDR_W-1:0] i_play_addr,
    output logic              o_init_start,
    output logic              o_rec_start,
    output logic              o_rec_pause,
    output logic              o_rec_stop,
    output logic              o_play_start,
    output logic              o_play_pause,
    output logic              o_play_stop,
    output logic              o_play_en,
    output logic              o_sram_sel,
    output logic [ADDR_W-1:0] o_rec_end_addr,
    output logic              o_rec_valid,
    output logic [SPEED_W-1:0] o_speed,
    output logic              o_fast,
    output logic              o_slow_0,
    output logic              o_slow_1,
    output logic [2:0]        o_state
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_I2C_INIT   = 3'd1,
        S_RECD       = 3'd2,
        S_RECD_PAUSE = 3'd3,
        S_PLAY       = 3'd4,
        S_PLAY_PAUSE = 3'd5
    } state_t;

    state_t              state, state_n;
    logic                init_issued, init_issued_n;
    logic                init_start_n;
    logic                rec_start_n, rec_pause_n, rec_stop_n;
    logic                play_start_n, play_pause_n, play_stop_n;
    logic                play_en_n, sram_sel_n;
    logic [ADDR_W-1:0]   rec_end_addr_n;
    logic                rec_valid_n;
    logic [SPEED_W-1:0]  speed_n;
    logic                fast_n, slow_0_n, slow_1_n;
    logic                rec_full, play_done;

    assign rec_full  = &i_rec_addr;
    assign play_done = (i_play_addr >= o_rec_end_addr);
    assign o_state   = state;

    // Next-state, command pulses and settings; stop outranks rec, rec outranks play
    always_comb begin
        state_n        = state;
        init_issued_n  = init_issued;
        init_start_n   = 1'b0;
        rec_start_n    = 1'b0;
        rec_pause_n    = 1'b0;
        rec_stop_n     = 1'b0;
        play_start_n   = 1'b0;
        play_pause_n   = 1'b0;
        play_stop_n    = 1'b0;
        rec_end_addr_n = o_rec_end_addr;
        rec_valid_n    = o_rec_valid;
        speed_n        = o_speed;
        fast_n         = o_fast;
        slow_0_n       = o_slow_0;
        slow_1_n       = o_slow_1;

        case (state)
            S_I2C_INIT: begin
                if (!init_issued) begin
                    init_start_n  = 1'b1;
                    init_issued_n = 1'b1;
                end
                if (i_init_finished) state_n = S_IDLE;
            end
            S_IDLE: begin
                if (i_key_stop) begin
                    state_n = S_IDLE;
                end else if (i_key_rec) begin
                    state_n     = S_RECD;
                    rec_start_n = 1'b1;
                end else if (i_key_play && o_rec_valid) begin
                    state_n      = S_PLAY;
                    play_start_n = 1'b1;
                end
            end
            S_RECD: begin
                // A full SRAM ends the take exactly like a stop key
                if (i_key_stop || rec_full) begin
                    state_n        = S_IDLE;
                    rec_stop_n     = 1'b1;
                    rec_end_addr_n = i_rec_addr;
                    rec_valid_n    = (i_rec_addr != '0);
                end else if (i_key_rec) begin
                    state_n     = S_RECD_PAUSE;
                    rec_pause_n = 1'b1;
                end
            end
            S_RECD_PAUSE: begin
                if (i_key_stop) begin
                    state_n        = S_IDLE;
                    rec_stop_n     = 1'b1;
                    rec_end_addr_n = i_rec_addr;
                    rec_valid_n    = (i_rec_addr != '0);
                end else if (i_key_rec) begin
                    state_n     = S_RECD;
                    rec_start_n = 1'b1;
                end
            end
            S_PLAY: begin
                if (i_key_stop || play_done) begin
                    state_n     = S_IDLE;
                    play_stop_n = 1'b1;
                end else if (i_key_play) begin
                    state_n      = S_PLAY_PAUSE;
                    play_pause_n = 1'b1;
                end
            end
            S_PLAY_PAUSE: begin
                if (i_key_stop) begin
                    state_n     = S_IDLE;
                    play_stop_n = 1'b1;
                end else if (i_key_play) begin
                    state_n      = S_PLAY;
                    play_start_n = 1'b1;
                end
            end
            default: state_n = S_I2C_INIT;
        endcase

        if (state != S_I2C_INIT) begin
            if (i_key_spd_up && !i_key_spd_dn && (o_speed < SPEED_W'(MAX_SPEED)))
                speed_n = o_speed + SPEED_W'(1);
            else if (i_key_spd_dn && !i_key_spd_up && (o_speed > SPEED_W'(1)))
                speed_n = o_speed - SPEED_W'(1);
            if (i_key_mode) begin
                fast_n   = o_slow_1;
                slow_0_n = o_fast;
                slow_1_n = o_slow_0;
            end
        end

        play_en_n  = (state_n == S_PLAY);
        sram_sel_n = (state_n == S_RECD);
    end

    // State and registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state          <= S_I2C_INIT;
            init_issued    <= 1'b0;
            o_init_start   <= 1'b0;
            o_rec_start    <= 1'b0;
            o_rec_pause    <= 1'b0;
            o_rec_stop     <= 1'b0;
            o_play_start   <= 1'b0;
            o_play_pause   <= 1'b0;
            o_play_stop    <= 1'b0;
            o_play_en      <= 1'b0;
            o_sram_sel     <= 1'b0;
            o_rec_end_addr <= '0;
            o_rec_valid    <= 1'b0;
            o_speed        <= SPEED_W'(1);
            o_fast         <= 1'b1;
            o_slow_0       <= 1'b0;
            o_slow_1       <= 1'b0;
        end else begin
            state          <= state_n;
            init_issued    <= init_issued_n;
            o_init_start   <= init_start_n;
            o_rec_start    <= rec_start_n;
            o_rec_pause    <= rec_pause_n;
            o_rec_stop     <= rec_stop_n;
            o_play_start   <= play_start_n;
            o_play_pause   <= play_pause_n;
            o_play_stop    <= play_stop_n;
            o_play_en      <= play_en_n;
            o_sram_sel     <= sram_sel_n;
            o_rec_end_addr <= rec_end_addr_n;
            o_rec_valid    <= rec_valid_n;
            o_speed        <= speed_n;
            o_fast         <= fast_n;
            o_slow_0       <= slow_0_n;
            o_slow_1       <= slow_1_n;
        end
    end

endmodule

// File: tb/tb_aud_mode_ctrl.sv
// Directed bench for aud_mode_ctrl: a per-cycle vector table plus hand sequences
// for init, speed/mode saturation and reset during playback.
module tb_aud_mode_ctrl;

    localparam int unsigned ADDR_W  = 20;
    localparam int unsigned SPEED_W = 4;

    localparam logic [5:0] K_REC  = 6'h01;
    localparam logic [5:0] K_PLAY = 6'h02;
    localparam logic [5:0] K_STOP = 6'h04;
    localparam logic [5:0] K_UP   = 6'h08;
    localparam logic [5:0] K_DN   = 6'h10;
    localparam logic [5:0] K_MODE = 6'h20;

    // {init_start, rec_start, rec_pause, rec_stop, play_start, play_pause, play_stop}
    localparam logic [6:0] P_INIT  = 7'b1000000;
    localparam logic [6:0] P_RS    = 7'b0100000;
    localparam logic [6:0] P_RP    = 7'b0010000;
    localparam logic [6:0] P_RSTOP = 7'b0001000;
    localparam logic [6:0] P_PS    = 7'b0000100;
    localparam logic [6:0] P_PP    = 7'b0000010;
    localparam logic [6:0] P_PSTOP = 7'b0000001;

    typedef struct packed {
        logic [5:0]        keys;
        logic [ADDR_W-1:0] rec_addr;
        logic [ADDR_W-1:0] play_addr;
        logic [2:0]        st;
        logic [6:0]        pulses;
        logic              sel;
        logic              pen;
        logic              valid;
        logic [ADDR_W-1:0] end_addr;
        logic [SPEED_W-1:0] spd;
    } vec_t;

    logic i_clk = 1'b0;
    logic i_rst;
    logic i_init_finished;
    logic i_key_rec, i_key_play, i_key_stop, i_key_spd_up, i_key_spd_dn, i_key_mode;
    logic [ADDR_W-1:0] i_rec_addr, i_play_addr;
    logic o_init_start, o_rec_start, o_rec_pause, o_rec_stop;
    logic o_play_start, o_play_pause, o_play_stop, o_play_en, o_sram_sel;
    logic [ADDR_W-1:0] o_rec_end_addr;
    logic o_rec_valid;
    logic [SPEED_W-1:0] o_speed;
    logic o_fast, o_slow_0, o_slow_1;
    logic [2:0] o_state;

    int errors = 0;
    int checks = 0;
    int row    = 0;
    vec_t vec[$];

    always #5 i_clk = ~i_clk;

    aud_mode_ctrl #(.ADDR_W(ADDR_W), .SPEED_W(SPEED_W), .MAX_SPEED(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_init_finished(i_init_finished),
        .i_key_rec(i_key_rec), .i_key_play(i_key_play), .i_key_stop(i_key_stop),
        .i_key_spd_up(i_key_spd_up), .i_key_spd_dn(i_key_spd_dn), .i_key_mode(i_key_mode),
        .i_rec_addr(i_rec_addr), .i_play_addr(i_play_addr),
        .o_init_start(o_init_start), .o_rec_start(o_rec_start), .o_rec_pause(o_rec_pause),
        .o_rec_stop(o_rec_stop), .o_play_start(o_play_start), .o_play_pause(o_play_pause),
        .o_play_stop(o_play_stop), .o_play_en(o_play_en), .o_sram_sel(o_sram_sel),
        .o_rec_end_addr(o_rec_end_addr), .o_rec_valid(o_rec_valid), .o_speed(o_speed),
        .o_fast(o_fast), .o_slow_0(o_slow_0), .o_slow_1(o_slow_1), .o_state(o_state)
    );

    function automatic logic [6:0] pulses();
        return {o_init_start, o_rec_start, o_rec_pause, o_rec_stop,
                o_play_start, o_play_pause, o_play_stop};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (row %0d): got %h, expected %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] k, input logic [ADDR_W-1:0] ra,
                         input logic [ADDR_W-1:0] pa);
        i_key_rec    = k[0];
        i_key_play   = k[1];
        i_key_stop   = k[2];
        i_key_spd_up = k[3];
        i_key_spd_dn = k[4];
        i_key_mode   = k[5];
        i_rec_addr   = ra;
        i_play_addr  = pa;
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_reset_vals();
        chk("rst_state", 32'(o_state), 32'd1);
        chk("rst_pulses", 32'(pulses()), 32'd0);
        chk("rst_play_en", 32'(o_play_en), 32'd0);
        chk("rst_sram_sel", 32'(o_sram_sel), 32'd0);
        chk("rst_end_addr", 32'(o_rec_end_addr), 32'd0);
        chk("rst_valid", 32'(o_rec_valid), 32'd0);
        chk("rst_speed", 32'(o_speed), 32'd1);
        chk("rst_mode", 32'({o_slow_1, o_slow_0, o_fast}), 32'b001);
    endtask

    task automatic add(input logic [5:0] k, input logic [ADDR_W-1:0] ra,
                       input logic [ADDR_W-1:0] pa, input logic [2:0] st,
                       input logic [6:0] pl, input logic sel, input logic pen,
                       input logic val, input logic [ADDR_W-1:0] ea,
                       input logic [SPEED_W-1:0] spd);
        vec_t v;
        v.keys = k; v.rec_addr = ra; v.play_addr = pa; v.st = st; v.pulses = pl;
        v.sel = sel; v.pen = pen; v.valid = val; v.end_addr = ea; v.spd = spd;
        vec.push_back(v);
    endtask

    initial begin
        int init_cnt;
        int exp_spd;
        logic [2:0] exp_mode;

        // keys, rec_addr, play_addr | state, pulses, sel, play_en, valid, end_addr, speed
        add(K_PLAY, 20'h0, 20'h0, 3'd0, 7'd0, 0, 0, 0, 20'h0, 4'd1);
        add(K_STOP, 20'h0, 20'h0, 3'd0, 7'd0, 0, 0, 0, 20'h0, 4'd1);
        add(K_REC, 20'h10, 20'h0, 3'd2, P_RS, 1, 0, 0, 20'h0, 4'd1);
        add(6'h0, 20'h100, 20'h0, 3'd2, 7'd0, 1, 0, 0, 20'h0, 4'd1);
        add(K_REC, 20'h200, 20'h0, 3'd3, P_RP, 0, 0, 0, 20'h0, 4'd1);
        add(K_PLAY, 20'h200, 20'h0, 3'd3, 7'd0, 0, 0, 0, 20'h0, 4'd1);
        add(K_REC, 20'h200, 20'h0, 3'd2, P_RS, 1, 0, 0, 20'h0, 4'd1);
        add(K_STOP, 20'h400, 20'h0, 3'd0, P_RSTOP, 0, 0, 1, 20'h400, 4'd1);
        add(K_PLAY, 20'h0, 20'h0, 3'd4, P_PS, 0, 1, 1, 20'h400, 4'd1);
        add(K_UP, 20'h0, 20'h100, 3'd4, 7'd0, 0, 1, 1, 20'h400, 4'd2);
        add(K_REC, 20'h0, 20'h200, 3'd4, 7'd0, 0, 1, 1, 20'h400, 4'd2);
        add(K_PLAY, 20'h0, 20'h200, 3'd5, P_PP, 0, 0, 1, 20'h400, 4'd2);
        add(K_UP | K_DN, 20'h0, 20'h500, 3'd5, 7'd0, 0, 0, 1, 20'h400, 4'd2);
        add(K_PLAY, 20'h0, 20'h300, 3'd4, P_PS, 0, 1, 1, 20'h400, 4'd2);
        add(K_DN, 20'h0, 20'h3FF, 3'd4, 7'd0, 0, 1, 1, 20'h400, 4'd1);
        add(6'h0, 20'h0, 20'h400, 3'd0, P_PSTOP, 0, 0, 1, 20'h400, 4'd1);
        add(K_REC, 20'h0, 20'h0, 3'd2, P_RS, 1, 0, 1, 20'h400, 4'd1);
        add(K_STOP | K_REC | K_PLAY, 20'h123, 20'h0, 3'd0, P_RSTOP, 0, 0, 1, 20'h123, 4'd1);
        add(K_REC, 20'h0, 20'h0, 3'd2, P_RS, 1, 0, 1, 20'h123, 4'd1);
        add(K_STOP, 20'h0, 20'h0, 3'd0, P_RSTOP, 0, 0, 0, 20'h0, 4'd1);
        add(K_PLAY, 20'h0, 20'h0, 3'd0, 7'd0, 0, 0, 0, 20'h0, 4'd1);
        add(K_REC, 20'h800, 20'h0, 3'd2, P_RS, 1, 0, 0, 20'h0, 4'd1);
        add(6'h0, 20'hFFFFF, 20'h0, 3'd0, P_RSTOP, 0, 0, 1, 20'hFFFFF, 4'd1);

        i_rst = 1'b1;
        i_init_finished = 1'b0;
        drive(6'h0, '0, '0);
        #12;
        chk_reset_vals();

        // Init: held for 10 cycles with keys bouncing; only one init pulse, in cycle 1
        @(negedge i_clk);
        i_rst = 1'b0;
        init_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            row = 100 + i;
            drive((i % 2 == 0) ? (K_REC | K_PLAY | K_UP | K_MODE) : (K_STOP | K_DN),
                  20'hFFFFF, 20'h0);
            step();
            if (o_init_start) init_cnt++;
            chk("init_pulse", 32'(o_init_start), (i == 0) ? 32'd1 : 32'd0);
            chk("init_other_pulses", 32'(pulses() & ~P_INIT), 32'd0);
            chk("init_state", 32'(o_state), 32'd1);
        end
        chk("init_pulse_count", 32'(init_cnt), 32'd1);
        chk("init_speed", 32'(o_speed), 32'd1);
        chk("init_mode", 32'({o_slow_1, o_slow_0, o_fast}), 32'b001);
        drive(6'h0, '0, '0);
        i_init_finished = 1'b1;
        step();
        chk("init_done_state", 32'(o_state), 32'd0);
        chk("init_done_pulse", 32'(pulses()), 32'd0);

        foreach (vec[i]) begin
            row = i;
            drive(vec[i].keys, vec[i].rec_addr, vec[i].play_addr);
            step();
            chk("state", 32'(o_state), 32'(vec[i].st));
            chk("pulses", 32'(pulses()), 32'(vec[i].pulses));
            chk("sram_sel", 32'(o_sram_sel), 32'(vec[i].sel));
            chk("play_en", 32'(o_play_en), 32'(vec[i].pen));
            chk("rec_valid", 32'(o_rec_valid), 32'(vec[i].valid));
            chk("rec_end_addr", 32'(o_rec_end_addr), 32'(vec[i].end_addr));
            chk("speed", 32'(o_speed), 32'(vec[i].spd));
        end

        // Speed saturation and mode rotation, in IDLE
        exp_spd = 1;
        for (int i = 0; i < 10; i++) begin
            row = 200 + i;
            drive(K_UP, '0, '0);
            step();
            exp_spd = (exp_spd < 8) ? exp_spd + 1 : 8;
            chk("spd_up", 32'(o_speed), 32'(exp_spd));
        end
        for (int i = 0; i < 10; i++) begin
            row = 220 + i;
            drive(K_DN, '0, '0);
            step();
            exp_spd = (exp_spd > 1) ? exp_spd - 1 : 1;
            chk("spd_dn", 32'(o_speed), 32'(exp_spd));
        end
        row = 240;
        drive(K_UP, '0, '0);
        step();
        drive(K_UP | K_DN, '0, '0);
        step();
        chk("spd_up_dn", 32'(o_speed), 32'd2);
        exp_mode = 3'b001;
        for (int i = 0; i < 3; i++) begin
            row = 250 + i;
            drive(K_MODE, '0, '0);
            step();
            exp_mode = {exp_mode[1:0], exp_mode[2]};
            chk("mode", 32'({o_slow_1, o_slow_0, o_fast}), 32'(exp_mode));
        end

        // Asynchronous reset during playback
        row = 300;
        drive(K_PLAY, '0, '0);
        step();
        chk("pre_rst_state", 32'(o_state), 32'd4);
        drive(6'h0, '0, 20'h10);
        #3;
        i_rst = 1'b1;
        #1;
        chk_reset_vals();
        step();
        chk("rst_no_play_stop", 32'(o_play_stop), 32'd0);
        chk("rst_held_state", 32'(o_state), 32'd1);
        @(negedge i_clk);
        i_rst = 1'b0;
        step();
        chk("reinit_pulse", 32'(o_init_start), 32'd1);
        chk("reinit_state", 32'(o_state), 32'd0);
        step();
        chk("reinit_pulse_once", 32'(o_init_start), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aud_mode_ctrl.md
Name: aud_mode_ctrl

Overview:
- Top-level mode sequencer for the audio record/playback path.
- Takes debounced single-cycle key pulses and the WM8731 init handshake, runs the INIT/IDLE/RECORD/PLAY state machine, and issues registered start/pause/stop pulses to the recorder and the DSP.
- Owns SRAM direction select, the recorded-length register, and playback speed/interpolation settings.

Parameters:
- ADDR_W, 20, SRAM word address width
- SPEED_W, 4, width of speed factor
- MAX_SPEED, 8, upper saturation of speed factor (minimum is 1)

Ports:
- i_clk  in  1  system clock (BCLK domain); all logic on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_init_finished  in  1  level; I2C initializer done
- i_key_rec  in  1  pulse; record / record-pause toggle
- i_key_play  in  1  pulse; play / play-pause toggle
- i_key_stop  in  1  pulse; stop current operation
- i_key_spd_up  in  1  pulse; speed +1
- i_key_spd_dn  in  1  pulse; speed -1
- i_key_mode  in  1  pulse; cycle FAST -> SLOW0 -> SLOW1 -> FAST
- i_rec_addr  in  ADDR_W  recorder current write address
- i_play_addr  in  ADDR_W  DSP current read address
- o_init_start  out  1  one-cycle pulse starting I2C init
- o_rec_start / o_rec_pause / o_rec_stop  out  1 each  one-cycle pulses to recorder
- o_play_start / o_play_pause / o_play_stop  out  1 each  one-cycle pulses to DSP and player
- o_play_en  out  1  high in S_PLAY only
- o_sram_sel  out  1  1 = recorder drives SRAM (S_RECD), 0 = read side
- o_rec_end_addr  out  ADDR_W  last recorded address
- o_rec_valid  out  1  a recording exists
- o_speed  out  SPEED_W  speed factor, range 1..MAX_SPEED
- o_fast / o_slow_0 / o_slow_1  out  1 each  one-hot mode
- o_state  out  3  current state code

Behaviour:
- State codes: S_IDLE=0, S_I2C_INIT=1, S_RECD=2, S_RECD_PAUSE=3, S_PLAY=4, S_PLAY_PAUSE=5. All outputs are registered.
- Reset values:
  - state = S_I2C_INIT; all pulses 0; o_play_en = 0; o_sram_sel = 0.
  - o_rec_end_addr = 0; o_rec_valid = 0; o_speed = 1; o_fast = 1; slows = 0.
- Reset mid-operation returns to these values. No stop pulse is emitted on reset.
- S_I2C_INIT:
  - o_init_start pulses on the first clock after reset release, exactly once per reset.
  - i_init_finished = 1 goes to S_IDLE.
  - All keys, including speed and mode keys, are ignored in this state.
- Latency: a key sampled high at edge N updates the state and asserts the corresponding pulse at edge N (visible in cycle N+1). Each pulse lasts exactly one cycle.
- Key priority within a cycle: stop > rec > play. Lower-priority keys in the same cycle are dropped. Speed and mode keys are evaluated independently of this priority.
- S_IDLE:
  - rec -> S_RECD, with o_rec_start.
  - play with o_rec_valid = 1 -> S_PLAY, with o_play_start.
  - play with o_rec_valid = 0 is ignored.
  - stop is ignored.
- S_RECD:
  - rec -> S_RECD_PAUSE, with o_rec_pause.
  - stop -> S_IDLE, with o_rec_stop; latch o_rec_end_addr = i_rec_addr; o_rec_valid = (i_rec_addr != 0).
  - Auto-stop: i_rec_addr == all-ones behaves as stop, latching the all-ones address.
  - play is ignored.
- S_RECD_PAUSE:
  - rec -> S_RECD, with o_rec_start (resume).
  - stop behaves as in S_RECD.
  - play is ignored.
- S_PLAY:
  - play -> S_PLAY_PAUSE, with o_play_pause.
  - stop -> S_IDLE, with o_play_stop.
  - Auto-stop: i_play_addr >= o_rec_end_addr -> S_IDLE, with o_play_stop.
  - rec is ignored.
- S_PLAY_PAUSE:
  - play -> S_PLAY, with o_play_start.
  - stop -> S_IDLE, with o_play_stop.
  - rec is ignored. No auto-stop while paused.
- o_sram_sel = 1 only in S_RECD; it is 0 in S_RECD_PAUSE.
- Speed:
  - spd_up: o_speed + 1, saturating at MAX_SPEED.
  - spd_dn: o_speed - 1, saturating at 1.
  - up and dn in the same cycle: no change.
  - Accepted in every state except S_I2C_INIT.
- Mode:
  - i_key_mode rotates the one-hot mode; exactly one of o_fast/o_slow_0/o_slow_1 is high at all times.
  - Accepted in every state except S_I2C_INIT.
- A new recording overwrites o_rec_end_addr only when it stops.

Test Plan:
- Reset, hold i_init_finished = 0 for 10 cycles, then assert it -> exactly one o_init_start pulse in cycle 1; o_state 1 then 0; keys pressed during init produce no pulses.
- From IDLE: rec, wait, rec, rec, stop with i_rec_addr = 0x00400 -> states 2, 3, 2, 0; pulses o_rec_start, o_rec_pause, o_rec_start, o_rec_stop; o_sram_sel = 1 only in S_RECD; o_rec_end_addr = 0x00400; o_rec_valid = 1.
- Play after the above, ramp i_play_addr to 0x00400 -> o_play_start, o_play_en = 1, then o_play_stop in the same edge the compare hits; o_state = 0.
- Play pressed in IDLE after reset (o_rec_valid = 0) -> no pulse, state stays 0. stop+rec+play in the same cycle during S_RECD -> stop wins: o_rec_stop only.
- spd_up × 10 -> o_speed = 8. spd_dn × 10 -> 1. up+dn together -> unchanged. mode × 3 -> slow_0, slow_1, fast.
- Assert i_rst during S_PLAY -> outputs return to reset values asynchronously with no o_play_stop; o_rec_valid = 0; o_init_start pulses again after release.
